// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, captures results from two CDB ports,
// serves operand lookups with CDB forwarding, and retires completed entries in program order.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              CDBiscast,
  input  logic [TAG_W-1:0]  CDBrobNum,
  input  logic [DATA_W-1:0] CDBdata,
  input  logic              CDBiscast2,
  input  logic [TAG_W-1:0]  CDBrobNum2,
  input  logic [DATA_W-1:0] CDBdata2,
  input  logic [TAG_W-1:0]  index,
  output logic              ready,
  output logic [DATA_W-1:0] value,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] DEPTH_TAG = TAG_W'(DEPTH);

  logic              busy   [DEPTH];
  logic              done   [DEPTH];
  logic [REG_W-1:0]  dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head, tail;

  logic [PTR_W-1:0] cdb1_idx, cdb2_idx, lk_idx;
  logic do_alloc, do_commit, cdb1_hit, cdb2_hit;

  assign cdb1_idx = CDBrobNum[PTR_W-1:0];
  assign cdb2_idx = CDBrobNum2[PTR_W-1:0];
  assign lk_idx   = index[PTR_W-1:0];

  // Capacity is judged on the pre-edge count, so a full buffer never allocates on a retire edge.
  assign alloc_ready = (count < DEPTH_TAG) && !flush;
  assign alloc_tag   = TAG_W'(tail);
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_commit   = busy[head] && done[head];

  assign cdb1_hit = CDBiscast  && (CDBrobNum  < DEPTH_TAG) && busy[cdb1_idx] && !done[cdb1_idx];
  assign cdb2_hit = CDBiscast2 && (CDBrobNum2 < DEPTH_TAG) && busy[cdb2_idx] && !done[cdb2_idx];

  always_comb begin
    ready = 1'b0;
    value = '0;
    if (index < DEPTH_TAG) begin
      if (busy[lk_idx] && done[lk_idx]) begin
        ready = 1'b1;
        value = data_q[lk_idx];
      end else if (CDBiscast && CDBrobNum == index && busy[lk_idx]) begin
        ready = 1'b1;
        value = CDBdata;
      end else if (CDBiscast2 && CDBrobNum2 == index && busy[lk_idx]) begin
        ready = 1'b1;
        value = CDBdata2;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy[i] <= 1'b0;
        done[i] <= 1'b0;
      end
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_dest  <= '0;
      commit_data  <= '0;
    end else begin
      commit_valid <= do_commit;
      if (do_commit) begin
        commit_tag  <= TAG_W'(head);
        commit_dest <= dest_q[head];
        commit_data <= data_q[head];
        busy[head]  <= 1'b0;
        done[head]  <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      if (do_alloc) begin
        busy[tail]   <= 1'b1;
        done[tail]   <= 1'b0;
        dest_q[tail] <= alloc_dest;
        tail         <= tail + PTR_W'(1);
      end
      // Port 2 is written first so port 1 overrides it when both target one tag.
      if (cdb2_hit) begin
        data_q[cdb2_idx] <= CDBdata2;
        done[cdb2_idx]   <= 1'b1;
      end
      if (cdb1_hit) begin
        data_q[cdb1_idx] <= CDBdata;
        done[cdb1_idx]   <= 1'b1;
      end
      count <= count + TAG_W'(do_alloc) - TAG_W'(do_commit);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: one task per scenario with hand-computed expectations.
module tb_reorder_buffer;

  logic        clock = 1'b0;
  logic        reset, flush, alloc_valid;
  logic [4:0]  alloc_dest;
  logic        alloc_ready;
  logic [5:0]  alloc_tag;
  logic        CDBiscast, CDBiscast2;
  logic [5:0]  CDBrobNum, CDBrobNum2;
  logic [31:0] CDBdata, CDBdata2;
  logic [5:0]  index;
  logic        ready;
  logic [31:0] value;
  logic        commit_valid;
  logic [5:0]  commit_tag;
  logic [4:0]  commit_dest;
  logic [31:0] commit_data;
  logic [5:0]  count;

  int nvec = 0;
  int nerr = 0;

  reorder_buffer dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .CDBiscast(CDBiscast), .CDBrobNum(CDBrobNum), .CDBdata(CDBdata),
    .CDBiscast2(CDBiscast2), .CDBrobNum2(CDBrobNum2), .CDBdata2(CDBdata2),
    .index(index), .ready(ready), .value(value),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_dest(commit_dest), .commit_data(commit_data), .count(count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; alloc_valid = 0; alloc_dest = 0;
    CDBiscast = 0; CDBrobNum = 0; CDBdata = 0;
    CDBiscast2 = 0; CDBrobNum2 = 0; CDBdata2 = 0;
    index = 6'd16;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1; alloc_dest = 5'(i);
      step();
    end
    alloc_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    nvec++; if (count !== 6'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", count); end
    nvec++; if (alloc_ready !== 1'b1) begin nerr++; $display("FAIL reset_alloc_ready got %b want 1", alloc_ready); end
    nvec++; if (alloc_tag !== 6'd0) begin nerr++; $display("FAIL reset_alloc_tag got %0d want 0", alloc_tag); end
    nvec++; if (commit_valid !== 1'b0) begin nerr++; $display("FAIL reset_commit_valid got %b want 0", commit_valid); end
    index = 6'd16; #1;
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL reset_lookup16 got %b want 0", ready); end
  endtask

  task automatic test_in_order();
    do_reset();
    alloc_valid = 1; alloc_dest = 5'd3; #1;
    nvec++; if (alloc_tag !== 6'd0) begin nerr++; $display("FAIL order_tag0 got %0d want 0", alloc_tag); end
    step();
    alloc_dest = 5'd4; #1;
    nvec++; if (alloc_tag !== 6'd1) begin nerr++; $display("FAIL order_tag1 got %0d want 1", alloc_tag); end
    step();
    alloc_dest = 5'd5; step();
    alloc_valid = 0;
    nvec++; if (count !== 6'd3) begin nerr++; $display("FAIL order_count3 got %0d want 3", count); end
    CDBiscast = 1; CDBrobNum = 6'd1; CDBdata = 32'h22; step();
    CDBiscast = 0;
    nvec++; if (commit_valid !== 1'b0) begin nerr++; $display("FAIL order_no_early_commit got %b want 0", commit_valid); end
    index = 6'd1; #1;
    nvec++; if (ready !== 1'b1 || value !== 32'h22) begin nerr++; $display("FAIL order_lookup1 got %b/%h want 1/22", ready, value); end
    CDBiscast2 = 1; CDBrobNum2 = 6'd0; CDBdata2 = 32'h11; step();
    CDBiscast2 = 0;
    nvec++; if (commit_valid !== 1'b0) begin nerr++; $display("FAIL order_latency got %b want 0", commit_valid); end
    step();
    nvec++; if (commit_valid !== 1'b1 || commit_tag !== 6'd0 || commit_dest !== 5'd3 || commit_data !== 32'h11) begin
      nerr++; $display("FAIL order_commit0 got %b/%0d/%0d/%h want 1/0/3/11", commit_valid, commit_tag, commit_dest, commit_data);
    end
    step();
    nvec++; if (commit_valid !== 1'b1 || commit_tag !== 6'd1 || commit_dest !== 5'd4 || commit_data !== 32'h22) begin
      nerr++; $display("FAIL order_commit1 got %b/%0d/%0d/%h want 1/1/4/22", commit_valid, commit_tag, commit_dest, commit_data);
    end
    step();
    nvec++; if (commit_valid !== 1'b0) begin nerr++; $display("FAIL order_tag2_held got %b want 0", commit_valid); end
    nvec++; if (count !== 6'd1) begin nerr++; $display("FAIL order_count1 got %0d want 1", count); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    alloc_n(16);
    nvec++; if (alloc_ready !== 1'b0) begin nerr++; $display("FAIL full_alloc_ready got %b want 0", alloc_ready); end
    nvec++; if (count !== 6'd16) begin nerr++; $display("FAIL full_count got %0d want 16", count); end
    CDBiscast = 1; CDBrobNum = 6'd0; CDBdata = 32'h55; step();
    CDBiscast = 0;
    alloc_valid = 1; alloc_dest = 5'd9; #1;
    nvec++; if (alloc_ready !== 1'b0) begin nerr++; $display("FAIL full_ready_before_commit got %b want 0", alloc_ready); end
    step();
    nvec++; if (commit_valid !== 1'b1 || commit_tag !== 6'd0 || commit_data !== 32'h55) begin
      nerr++; $display("FAIL full_commit got %b/%0d/%h want 1/0/55", commit_valid, commit_tag, commit_data);
    end
    nvec++; if (count !== 6'd15) begin nerr++; $display("FAIL full_count15 got %0d want 15", count); end
    nvec++; if (alloc_tag !== 6'd0 || alloc_ready !== 1'b1) begin nerr++; $display("FAIL full_wrap_tag got %0d/%b want 0/1", alloc_tag, alloc_ready); end
    step();
    alloc_valid = 0;
    nvec++; if (count !== 6'd16 || alloc_tag !== 6'd1) begin nerr++; $display("FAIL full_realloc got %0d/%0d want 16/1", count, alloc_tag); end
  endtask

  task automatic test_forward();
    do_reset();
    alloc_n(6);
    index = 6'd5;
    CDBiscast = 1; CDBrobNum = 6'd5; CDBdata = 32'hABCD; #1;
    nvec++; if (ready !== 1'b1 || value !== 32'hABCD) begin nerr++; $display("FAIL fwd_port1 got %b/%h want 1/abcd", ready, value); end
    CDBiscast = 0; CDBiscast2 = 1; CDBrobNum2 = 6'd5; CDBdata2 = 32'h77; #1;
    nvec++; if (ready !== 1'b1 || value !== 32'h77) begin nerr++; $display("FAIL fwd_port2 got %b/%h want 1/77", ready, value); end
    CDBiscast = 1; CDBdata = 32'h1; CDBdata2 = 32'h2; #1;
    nvec++; if (value !== 32'h1) begin nerr++; $display("FAIL fwd_priority got %h want 1", value); end
    step();
    CDBiscast = 0; CDBiscast2 = 0; #1;
    nvec++; if (ready !== 1'b1 || value !== 32'h1) begin nerr++; $display("FAIL both_ports_entry got %b/%h want 1/1", ready, value); end
    CDBiscast2 = 1; CDBrobNum2 = 6'd5; CDBdata2 = 32'h3; step();
    CDBiscast2 = 0;
    nvec++; if (value !== 32'h1) begin nerr++; $display("FAIL no_overwrite got %h want 1", value); end
    index = 6'd4; #1;
    nvec++; if (ready !== 1'b0 || value !== 32'h0) begin nerr++; $display("FAIL lookup_pending got %b/%h want 0/0", ready, value); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(4);
    CDBiscast = 1; CDBrobNum = 6'd0; CDBdata = 32'hF0;
    CDBiscast2 = 1; CDBrobNum2 = 6'd1; CDBdata2 = 32'hF1;
    alloc_valid = 1; alloc_dest = 5'd7; flush = 1; #1;
    nvec++; if (alloc_ready !== 1'b0) begin nerr++; $display("FAIL flush_alloc_ready got %b want 0", alloc_ready); end
    step();
    idle_inputs(); #1;
    nvec++; if (count !== 6'd0 || alloc_tag !== 6'd0) begin nerr++; $display("FAIL flush_state got %0d/%0d want 0/0", count, alloc_tag); end
    for (int i = 0; i < 3; i++) begin
      nvec++; if (commit_valid !== 1'b0) begin nerr++; $display("FAIL flush_no_commit cycle %0d got %b want 0", i, commit_valid); end
      step();
    end
  endtask

  task automatic test_non_busy();
    do_reset();
    CDBiscast = 1; CDBrobNum = 6'd7; CDBdata = 32'h99; step();
    CDBiscast = 0;
    nvec++; if (count !== 6'd0) begin nerr++; $display("FAIL nonbusy_count got %0d want 0", count); end
    alloc_n(8);
    index = 6'd7; #1;
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL nonbusy_realloc got %b want 0", ready); end
    CDBiscast = 1; CDBrobNum = 6'd16; CDBdata = 32'hBAD; step();
    CDBiscast = 0; index = 6'd0; #1;
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL tag16_ignored got %b want 0", ready); end
    step(); step();
    nvec++; if (commit_valid !== 1'b0 || count !== 6'd8) begin nerr++; $display("FAIL nonbusy_hold got %b/%0d want 0/8", commit_valid, count); end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_in_order();
    test_full_wrap();
    test_forward();
    test_flush();
    test_non_busy();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
